// File: rtl/button_conditioner.sv
// Six-channel push-button front end: two-flop synchroniser, debounce, press pulse
// and per-channel auto-repeat, with all output pulses registered.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned REPEAT_DELAY    = 4000000,
  parameter int unsigned REPEAT_PERIOD   = 1000000,
  parameter int unsigned TMR_W           = 23,
  parameter logic [5:0]  REPEAT_MASK     = 6'b001111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] btn_raw,
  output logic       move_left,
  output logic       move_right,
  output logic       aim_left,
  output logic       aim_right,
  output logic       shoot,
  output logic       start_new_game,
  output logic [5:0] btn_level
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  logic [5:0]       sync1, sync2, stable, stable_d;
  logic [5:0]       press, rep_pulse, pulse_q;
  logic [CNT_W-1:0] cnt [6];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      pulse_q  <= '0;
      for (int unsigned i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      pulse_q  <= press | rep_pulse;
      // A disagreement must persist DEBOUNCE_CYCLES consecutive cycles to be accepted.
      for (int unsigned i = 0; i < 6; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = stable & ~stable_d;

  for (genvar g = 0; g < 6; g++) begin : g_rep
    rep_state_t       state, state_next;
    logic [TMR_W-1:0] tmr, tmr_next;
    logic             fire;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= IDLE;
        tmr   <= '0;
      end else begin
        state <= state_next;
        tmr   <= tmr_next;
      end
    end

    always_comb begin
      state_next = state;
      tmr_next   = tmr + TMR_W'(1);
      case (state)
        IDLE: begin
          tmr_next = '0;
          if (REPEAT_MASK[g] && press[g]) state_next = DELAY;
        end
        DELAY: begin
          if (!stable[g]) begin
            state_next = IDLE;
            tmr_next   = '0;
          end else if (tmr == TMR_W'(REPEAT_DELAY - 1)) begin
            state_next = REPEAT;
            tmr_next   = '0;
          end
        end
        REPEAT: begin
          if (!stable[g]) begin
            state_next = IDLE;
            tmr_next   = '0;
          end else if (tmr == TMR_W'(REPEAT_PERIOD - 1)) begin
            tmr_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
          tmr_next   = '0;
        end
      endcase
    end

    // Release wins: a repeat fires only while the debounced level is still high.
    always_comb begin
      fire = 1'b0;
      case (state)
        DELAY:   fire = stable[g] && (tmr == TMR_W'(REPEAT_DELAY - 1));
        REPEAT:  fire = stable[g] && (tmr == TMR_W'(REPEAT_PERIOD - 1));
        default: fire = 1'b0;
      endcase
    end

    assign rep_pulse[g] = fire;
  end

  assign move_left      = pulse_q[0];
  assign move_right     = pulse_q[1];
  assign aim_left       = pulse_q[2];
  assign aim_right      = pulse_q[3];
  assign shoot          = pulse_q[4];
  assign start_new_game = pulse_q[5];
  assign btn_level      = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: table-driven press scenarios plus bounce and reset
// sequences, checked every cycle against a queue of expected {level, pulse} words.
module tb_button_conditioner;

  localparam logic [5:0] REP_EN = 6'b001111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] btn_raw;
  logic       move_left, move_right, aim_left, aim_right, shoot, start_new_game;
  logic [5:0] btn_level;
  logic [5:0] pulses;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4),
    .TMR_W(4),
    .REPEAT_MASK(6'b001111)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .move_left(move_left),
    .move_right(move_right),
    .aim_left(aim_left),
    .aim_right(aim_right),
    .shoot(shoot),
    .start_new_game(start_new_game),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  assign pulses = {start_new_game, shoot, aim_right, aim_left, move_right, move_left};

  int          errors = 0;
  int          checks = 0;
  int          edge_no = 0;
  int          pcnt [6];
  string       phase = "reset";
  logic [11:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected trace for raw held high on edges s .. s+hold-1 for the given channels.
  task automatic push_trace(input logic [5:0] chans, input int s, input int hold,
                            input int first, input int last);
    for (int k = first; k <= last; k++) begin
      logic [5:0] lvl;
      logic [5:0] pls;
      lvl = '0;
      pls = '0;
      for (int c = 0; c < 6; c++) begin
        if (chans[c] && hold >= 4) begin
          if (k >= s + 5 && k <= s + hold + 4) lvl[c] = 1'b1;
          if (k == s + 6) pls[c] = 1'b1;
          if (REP_EN[c])
            for (int e = s + 14; e <= s + hold + 5; e += 4)
              if (k == e) pls[c] = 1'b1;
        end
      end
      exp_q.push_back({lvl, pls});
    end
  endtask

  always @(posedge clk) begin
    logic [11:0] expv;
    #1;
    edge_no++;
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
    check($sformatf("%s t%0d", phase, edge_no), {20'h0, btn_level, pulses}, {20'h0, expv});
    for (int c = 0; c < 6; c++) if (pulses[c]) pcnt[c]++;
  end

  typedef struct {
    string      name;
    logic [5:0] chans;
    int         hold;
    int         exp_pulses;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int len;
    int ch;
    tbl[0] = '{"clean_shoot",  6'b010000, 30, 1};
    tbl[1] = '{"repeat_aim_l", 6'b000100, 40, 9};
    tbl[2] = '{"glitch_start", 6'b100000, 3,  0};
    tbl[3] = '{"simul_mr_ar",  6'b001010, 6,  1};
    tbl[4] = '{"min_hold_ml",  6'b000001, 4,  1};
    tbl[5] = '{"repeat_mr",    6'b000010, 20, 4};
    tbl[6] = '{"repeat_ar14",  6'b001000, 14, 3};
    tbl[7] = '{"repeat_ar12",  6'b001000, 12, 2};
    tbl[8] = '{"shoot_hold9",  6'b010000, 9,  1};

    btn_raw = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    phase = "idle";
    repeat (3) @(negedge clk);

    foreach (tbl[i]) begin
      phase = tbl[i].name;
      for (int c = 0; c < 6; c++) pcnt[c] = 0;
      len = tbl[i].hold + 14;
      for (int k = 1; k <= len; k++) begin
        @(negedge clk);
        if (k == 1) push_trace(tbl[i].chans, 1, tbl[i].hold, 1, len);
        btn_raw = (k <= tbl[i].hold) ? tbl[i].chans : 6'b0;
      end
      @(negedge clk);
      ch = 0;
      while (ch < 5 && !tbl[i].chans[ch]) ch++;
      check($sformatf("%s pulse_count", tbl[i].name), pcnt[ch], tbl[i].exp_pulses);
    end

    // Bounce 1,0,1,0 then steady high from edge 5.
    phase = "bounce";
    len = 4 + 20 + 14;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) push_trace(6'b000001, 5, 20, 1, len);
      if (k <= 4)       btn_raw = {5'b0, k[0]};
      else if (k <= 24) btn_raw = 6'b000001;
      else              btn_raw = '0;
    end
    @(negedge clk);

    // Press held across a reset pulse covering edges 5 and 6.
    phase = "reset_early";
    len = 16 + 14;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) push_trace(6'b000001, 7, 10, 1, len);
      btn_raw = (k <= 16) ? 6'b000001 : 6'b0;
      if (k == 5) begin
        reset_n = 1'b0;
        #1 check("reset_early async_clear", {20'h0, btn_level, pulses}, 32'h0);
      end
      if (k == 7) reset_n = 1'b1;
    end
    @(negedge clk);

    // Reset after the level is already high must clear it asynchronously.
    phase = "reset_late";
    len = 17 + 14;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) begin
        push_trace(6'b001000, 1, 100, 1, 9);
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h000);
        push_trace(6'b001000, 12, 6, 12, len);
      end
      btn_raw = (k <= 17) ? 6'b001000 : 6'b0;
      if (k == 10) begin
        reset_n = 1'b0;
        #1 check("reset_late async_level", {26'h0, btn_level}, 32'h0);
      end
      if (k == 12) reset_n = 1'b1;
    end
    repeat (2) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end input stage that sits directly upstream of the controls block.
- Takes six raw, asynchronous, bouncy push-button inputs from the board pins and registers them.
- For each button it synchronises the input, debounces it, and converts each press into a single-cycle pulse.
- Move and aim buttons can auto-repeat while held. Outputs drive the controls block's move_left, move_right, aim_left, aim_right, shoot and start_new_game inputs one-to-one.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised level must differ from the stable level before it is accepted (>=2).
- CNT_W, 16: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- REPEAT_DELAY, 4000000: cycles from the initial press pulse to the first repeat pulse (>=2).
- REPEAT_PERIOD, 1000000: cycles between successive repeat pulses (>=2).
- TMR_W, 23: repeat timer width; must hold max(REPEAT_DELAY, REPEAT_PERIOD)-1.
- REPEAT_MASK, 6'b001111: per-channel auto-repeat enable (bit order as btn_raw).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset; one clock domain, clk.
- btn_raw  input  6  raw pins. Bit mapping: [0] move_left, [1] move_right, [2] aim_left, [3] aim_right, [4] shoot, [5] start_new_game. Active-high.
- move_left  output  1  press/repeat pulse, channel 0.
- move_right  output  1  pulse, channel 1.
- aim_left  output  1  pulse, channel 2.
- aim_right  output  1  pulse, channel 3.
- shoot  output  1  pulse, channel 4.
- start_new_game  output  1  pulse, channel 5.
- btn_level  output  6  debounced stable level per channel.

Behaviour:
- Reset (reset_n low, asynchronous) clears every register: sync flops, stable levels, counters, timers, FSMs. All outputs read 0 while reset is low and until the first qualifying event afterwards. Reset mid-press discards the press: no pulse is emitted. A button still held at reset release must re-debounce (DEBOUNCE_CYCLES) and then produces one initial pulse.
- Synchroniser: two flops per channel. Only the second flop (sync) is used downstream.
- Debounce, per channel:
  - If sync == stable, counter is cleared to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0; else counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - btn_level = stable.
- Press pulse: a registered stable 0->1 edge produces a pulse exactly one cycle wide.
  - Latency: raw rises and holds before edge 1; pulse is high in the cycle after edge DEBOUNCE_CYCLES+3.
- Auto-repeat FSM, per channel. States are IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on the press pulse; timer cleared.
  - DELAY: timer increments each cycle. At timer == REPEAT_DELAY-1 the block emits a one-cycle pulse, clears the timer and moves to REPEAT. First repeat pulse is REPEAT_DELAY cycles after the initial pulse.
  - REPEAT: at timer == REPEAT_PERIOD-1 the block emits a pulse and clears the timer. Pulses occur every REPEAT_PERIOD cycles.
  - From DELAY or REPEAT, stable == 0 moves to IDLE immediately. Release has priority: no pulse on that edge or later.
  - Channels with REPEAT_MASK bit 0 stay in IDLE, so exactly one pulse per press.
- Release (stable 1->0) never generates a pulse.
- Channels are fully independent; no arbitration. Simultaneous presses produce simultaneous pulses, and the downstream controls block rejects multi-button cycles.
- Output pulse = press pulse OR repeat pulse, registered. Never wider than one cycle per event.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, default REPEAT_MASK):
- Clean press: btn_raw[4] rises and holds 30 cycles -> shoot high only in the cycle after edge 7; no repeat; btn_level[4]=1 from edge 6.
- Bounce: btn_raw[0] toggles 1,0,1,0 on alternate cycles, then holds 1 -> no pulse during bouncing; one move_left pulse 7 cycles after the final rise, at edge 7 counted from that rise.
- Auto-repeat: btn_raw[2] held 40 cycles -> aim_left pulses at edges 7, 15, 19, 23, 27, ... Release gives no further pulses once btn_level[2] falls; no release pulse.
- Short glitch: btn_raw[5] high for 3 cycles -> start_new_game and btn_level[5] stay 0.
- Simultaneous: btn_raw[1] and btn_raw[3] rise on the same cycle -> move_right and aim_right pulse on the same cycle (edge 7).
- Reset mid-operation: btn_raw[0] held, reset_n low at edge 5 for 2 cycles, then high -> no pulse during or right after reset. One pulse 7 edges after reset_n deassertion; all outputs 0 while reset_n is low.
